// File: rtl/arbitrated_stream_mux_pkg.sv
// arbitrated_stream_mux_pkg: shared FSM encoding, clog2 helper and parameter legality check.
package arbitrated_stream_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic bit params_legal(input int num_requestors, input int max_beats);
        return (num_requestors >= 2) && (max_beats >= 2);
    endfunction

endpackage

// File: rtl/arbitrated_stream_mux_out_reg.sv
// stream_out_reg: single-entry valid/ready output register carrying data, last and source index.
module stream_out_reg #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_SRC_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [C_DATA_WIDTH-1:0] load_data,
    input  logic                    load_last,
    input  logic [C_SRC_WIDTH-1:0]  load_src,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [C_DATA_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic [C_SRC_WIDTH-1:0]  out_src,
    output logic                    free
);

    assign free = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (free) begin
            out_valid <= load;
            if (load) begin
                out_data <= load_data;
                out_last <= load_last;
                out_src  <= load_src;
            end
        end
    end

endmodule

// File: rtl/arbitrated_stream_mux.sv
// arbitrated_stream_mux: forwards one packet from the arbiter-granted source, then pulses grant_release.
module arbitrated_stream_mux
    import arbitrated_stream_mux_pkg::*;
#(
    parameter int C_NUM_REQUESTORS      = 8,
    parameter int C_DATA_WIDTH          = 64,
    parameter int C_MAX_BEATS           = 256,
    parameter int C_LOG2_NUM_REQUESTORS = clog2(C_NUM_REQUESTORS),
    parameter int C_BEAT_CNT_WIDTH      = clog2(C_MAX_BEATS + 1)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [C_NUM_REQUESTORS-1:0]              req_valid,
    input  logic [C_NUM_REQUESTORS*C_DATA_WIDTH-1:0] req_data,
    input  logic [C_NUM_REQUESTORS-1:0]              req_last,
    output logic [C_NUM_REQUESTORS-1:0]              req_ready,
    output logic [C_NUM_REQUESTORS-1:0]              requests,
    input  logic                                     grant_valid,
    input  logic [C_LOG2_NUM_REQUESTORS-1:0]         grant,
    input  logic [C_NUM_REQUESTORS-1:0]              grant_oh,
    output logic                                     grant_release,
    output logic                                     out_valid,
    output logic [C_DATA_WIDTH-1:0]                  out_data,
    output logic                                     out_last,
    output logic [C_LOG2_NUM_REQUESTORS-1:0]         out_src,
    input  logic                                     out_ready,
    output logic                                     err_overflow
);

    if (!params_legal(C_NUM_REQUESTORS, C_MAX_BEATS)) begin : g_bad_params
        $error("arbitrated_stream_mux: need C_NUM_REQUESTORS >= 2 and C_MAX_BEATS >= 2");
    end

    state_t                             state, state_nxt;
    logic [C_LOG2_NUM_REQUESTORS-1:0]   sel;
    logic [C_NUM_REQUESTORS-1:0]        sel_oh;
    logic [C_BEAT_CNT_WIDTH-1:0]        beat_cnt;
    logic                               cur_valid, cur_last, force_last, load_last, accept, out_free;
    logic [C_DATA_WIDTH-1:0]            cur_data;

    assign cur_valid     = req_valid[sel];
    assign cur_last      = req_last[sel];
    assign cur_data      = req_data[int'(sel)*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign force_last    = beat_cnt == C_BEAT_CNT_WIDTH'(C_MAX_BEATS - 1);
    assign load_last     = cur_last | force_last;
    assign accept        = (state == XFER) & cur_valid & out_free;
    assign requests      = req_valid;
    assign req_ready     = (state == XFER) ? (sel_oh & {C_NUM_REQUESTORS{out_free}}) : '0;
    assign grant_release = state == RELEASE;

    // SETTLE burns the cycle in which the arbiter still drops its old grant.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant_valid ? XFER : IDLE;
            XFER:    state_nxt = (accept && load_last) ? RELEASE : XFER;
            RELEASE: state_nxt = SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sel          <= '0;
            sel_oh       <= '0;
            beat_cnt     <= '0;
            err_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_valid) begin
                sel      <= grant;
                sel_oh   <= grant_oh;
                beat_cnt <= '0;
            end
            if (accept) beat_cnt <= beat_cnt + C_BEAT_CNT_WIDTH'(1);
            if (accept && force_last && !cur_last) err_overflow <= 1'b1;
        end
    end

    stream_out_reg #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_SRC_WIDTH  (C_LOG2_NUM_REQUESTORS)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (cur_data),
        .load_last (load_last),
        .load_src  (sel),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .free      (out_free)
    );

endmodule

// File: tb/tb_arbitrated_stream_mux.sv
// tb_arbitrated_stream_mux: table-driven packet vectors plus corner sequences, scoreboarded per source.
module tb_arbitrated_stream_mux;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid, req_last, req_ready, requests, grant_oh;
    logic [N*W-1:0] req_data;
    logic           grant_valid, grant_release, out_valid, out_last, out_ready, err_overflow;
    logic [1:0]     grant, out_src;
    logic [W-1:0]   out_data;

    always #5 clk = ~clk;

    arbitrated_stream_mux #(
        .C_NUM_REQUESTORS (N),
        .C_DATA_WIDTH     (W),
        .C_MAX_BEATS      (MB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .requests      (requests),
        .grant_valid   (grant_valid),
        .grant         (grant),
        .grant_oh      (grant_oh),
        .grant_release (grant_release),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_src       (out_src),
        .out_ready     (out_ready),
        .err_overflow  (err_overflow)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         exp_last;
    } beat_t;

    typedef struct {
        logic [N-1:0] srcs;
        int           len;
        bit           with_last;
        int           exp_beats;
        int           exp_rel;
        bit           exp_err;
    } vec_t;

    beat_t        srcq[N][$];
    beat_t        expq[N][$];
    int           pc[N];
    int           vectors = 0;
    int           miscompares = 0;
    int           out_beats = 0;
    int           in_fires = 0;
    int           rels = 0;
    int           cur_pkt = -1;
    int           stall_at = -1;
    int           stall_left = 0;
    logic         gv = 1'b0;
    logic [1:0]   gnt = 2'd3;
    logic         drop_gv = 1'b0;
    logic         rel_pend = 1'b0;
    logic         fire_prev = 1'b0;
    logic         hold_prev = 1'b0;
    logic [W-1:0] hold_data = '0;
    logic [13:0]  seqn = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = srcq[i].size() > 0;
            req_data[i*W +: W]  = (srcq[i].size() > 0) ? srcq[i][0].data : '0;
            req_last[i]         = (srcq[i].size() > 0) ? srcq[i][0].last : 1'b0;
        end
        grant_valid = gv & ~drop_gv;
        grant       = gnt;
        grant_oh    = 4'd1 << gnt;
    endtask

    // Expected beats (with forced-last folded in) are pushed as the packet is queued.
    task automatic load_pkt(input int src, input int len, input bit with_last);
        beat_t b;
        logic [1:0] s2;
        s2 = 2'(src);
        for (int k = 0; k < len; k++) begin
            b.data = {s2, seqn};
            seqn++;
            b.last = with_last && (k == len - 1);
            pc[src]++;
            b.exp_last = b.last || (pc[src] == MB);
            if (b.exp_last) pc[src] = 0;
            srcq[src].push_back(b);
            expq[src].push_back(b);
        end
        drive();
    endtask

    task automatic step();
        logic [N-1:0] fire, rv;
        logic         rel_s, rst_s, nrel, found;
        logic [1:0]   s, idx;
        beat_t        e;
        @(negedge clk);
        rst_s = rst;
        fire  = req_valid & req_ready;
        rv    = req_valid;
        rel_s = grant_release;
        if (!rst_s) begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
            if (fire_prev) chk("accept_latency", 32'(out_valid), 1);
            if (rel_s || rel_pend) chk("release_timing", 32'(rel_s), 32'(rel_pend));
            if (hold_prev) chk("hold_data", 32'(out_data), 32'(hold_data));
            if (out_valid && !out_ready) chk("ready_while_full", 32'(req_ready), 0);
            if (out_valid && out_ready) begin
                s = out_src;
                out_beats++;
                if (cur_pkt >= 0) chk("no_interleave", 32'(s), 32'(cur_pkt));
                chk("beat_expected", 32'(expq[s].size() != 0), 1);
                if (expq[s].size() != 0) begin
                    e = expq[s].pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_last", 32'(out_last), 32'(e.exp_last));
                end
                cur_pkt = out_last ? -1 : int'(s);
            end
            if (rel_s) rels++;
            nrel = 1'b0;
            for (int i = 0; i < N; i++)
                if (fire[i] && srcq[i].size() > 0) begin
                    in_fires++;
                    nrel |= srcq[i][0].exp_last;
                end
            rel_pend  = nrel;
            fire_prev = |fire;
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
        end else begin
            rel_pend  = 1'b0;
            fire_prev = 1'b0;
            hold_prev = 1'b0;
            cur_pkt   = -1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        // Registered round-robin arbiter: drops the grant the cycle after release.
        if (rst_s) begin
            gv  = 1'b0;
            gnt = 2'(N - 1);
        end else if (rel_s) begin
            gv = 1'b0;
        end else if (!gv && |rv) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = 2'((int'(gnt) + k) % N);
                if (!found && rv[idx]) begin
                    gnt   = idx;
                    found = 1'b1;
                end
            end
            gv = 1'b1;
        end
        if (stall_at >= 0 && out_beats >= stall_at) begin
            stall_left = 5;
            stall_at   = -1;
        end
        out_ready = stall_left == 0;
        if (stall_left > 0) stall_left--;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            expq[i].delete();
            pc[i] = 0;
        end
        drive();
        step();
        rst = 1'b0;
        drive();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant_release", 32'(grant_release), 0);
        chk("rst_err_overflow", 32'(err_overflow), 0);
        chk("rst_state", 32'(dut.state), 0);
        chk("rst_beat_cnt", 32'(dut.beat_cnt), 0);
        out_beats = 0;
        in_fires  = 0;
        rels      = 0;
    endtask

    task automatic drain(input string name);
        int c;
        bit busy;
        c = 0;
        busy = 1'b1;
        while (busy && c < 300) begin
            busy = out_valid;
            for (int i = 0; i < N; i++) if (srcq[i].size() > 0) busy = 1'b1;
            if (busy) begin
                step();
                c++;
            end
        end
        chk({name, "_drained"}, 32'(c < 300), 1);
        repeat (4) step();
    endtask

    task automatic exp_empty(input string name);
        int left;
        left = 0;
        for (int i = 0; i < N; i++) left += expq[i].size();
        chk({name, "_all_delivered"}, 32'(left), 0);
    endtask

    vec_t vt[6];

    initial begin
        int c;
        vt[0] = '{srcs: 4'b0100, len: 3, with_last: 1'b1, exp_beats: 3, exp_rel: 1, exp_err: 1'b0};
        vt[1] = '{srcs: 4'b0011, len: 2, with_last: 1'b1, exp_beats: 4, exp_rel: 2, exp_err: 1'b0};
        vt[2] = '{srcs: 4'b1000, len: 6, with_last: 1'b0, exp_beats: 6, exp_rel: 1, exp_err: 1'b1};
        vt[3] = '{srcs: 4'b0010, len: 4, with_last: 1'b1, exp_beats: 4, exp_rel: 1, exp_err: 1'b0};
        vt[4] = '{srcs: 4'b1111, len: 1, with_last: 1'b1, exp_beats: 4, exp_rel: 4, exp_err: 1'b0};
        vt[5] = '{srcs: 4'b0001, len: 8, with_last: 1'b1, exp_beats: 8, exp_rel: 2, exp_err: 1'b1};
        out_ready = 1'b1;
        drive();

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < N; i++) if (vt[v].srcs[i]) load_pkt(i, vt[v].len, vt[v].with_last);
            drain($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_beats", v), 32'(out_beats), 32'(vt[v].exp_beats));
            chk($sformatf("vec%0d_releases", v), 32'(rels), 32'(vt[v].exp_rel));
            chk($sformatf("vec%0d_err", v), 32'(err_overflow), 32'(vt[v].exp_err));
            exp_empty($sformatf("vec%0d", v));
        end

        // Downstream back-pressure for 5 cycles mid-packet.
        do_reset();
        load_pkt(2, 4, 1'b1);
        stall_at = 2;
        drain("stall");
        chk("stall_beats", 32'(out_beats), 4);
        chk("stall_releases", 32'(rels), 1);
        exp_empty("stall");

        // Reset mid-packet, then a fresh packet.
        do_reset();
        load_pkt(0, 5, 1'b1);
        c = 0;
        while (in_fires < 2 && c < 50) begin
            step();
            c++;
        end
        chk("midrst_reached_beat2", 32'(in_fires >= 2), 1);
        do_reset();
        load_pkt(3, 3, 1'b1);
        drain("postrst");
        chk("postrst_beats", 32'(out_beats), 3);
        chk("postrst_releases", 32'(rels), 1);
        exp_empty("postrst");

        // Arbiter drops grant_valid while a packet is in flight.
        do_reset();
        load_pkt(1, 4, 1'b1);
        load_pkt(2, 2, 1'b1);
        c = 0;
        while (in_fires < 1 && c < 50) begin
            step();
            c++;
        end
        chk("drop_started", 32'(in_fires >= 1), 1);
        drop_gv = 1'b1;
        drive();
        repeat (2) step();
        chk("drop_sel_held", 32'(dut.sel), 1);
        drop_gv = 1'b0;
        drive();
        drain("drop");
        chk("drop_beats", 32'(out_beats), 6);
        chk("drop_releases", 32'(rels), 2);
        exp_empty("drop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbitrated_stream_mux.md
# arbitrated_stream_mux

Multi-source packet multiplexer that sits directly downstream of `arbitration_nway_single_cycle`. It presents per-source valid lines to the arbiter as `requests` and consumes `grant_valid`/`grant`/`grant_oh`. It forwards exactly one packet from the granted source through a registered output stage, then pulses `grant_release` so the arbiter rotates to the next source. A beat counter bounds packet length and flags runaway sources.

## Interface
Parameters:
- `C_NUM_REQUESTORS`, 8: number of sources; must be ≥ 2.
- `C_DATA_WIDTH`, 64: beat payload width.
- `C_MAX_BEATS`, 256: maximum beats per packet before forced termination; must be ≥ 2.
- `C_LOG2_NUM_REQUESTORS`, derived as clog2(`C_NUM_REQUESTORS`).
- `C_BEAT_CNT_WIDTH`, derived as clog2(`C_MAX_BEATS`+1).

Ports (`[N]` = `C_NUM_REQUESTORS`):
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in [N]: per-source beat valid.
- `req_data` in [N*C_DATA_WIDTH]: source i occupies bits [i*W +: W].
- `req_last` in [N]: per-source end-of-packet.
- `req_ready` out [N]: per-source accept; at most one bit high.
- `requests` out [N]: equals `req_valid`, combinational; drives the arbiter.
- `grant_valid` in 1: from arbiter.
- `grant` in C_LOG2_NUM_REQUESTORS: from arbiter.
- `grant_oh` in [N]: from arbiter.
- `grant_release` out 1: one-cycle pulse to the arbiter, registered.
- `out_valid` out 1: output beat valid.
- `out_data` out C_DATA_WIDTH: output beat payload.
- `out_last` out 1: output end-of-packet.
- `out_src` out C_LOG2_NUM_REQUESTORS: source index of the beat.
- `out_ready` in 1: downstream accept.
- `err_overflow` out 1: sticky; set on forced termination, cleared only by `rst`.

## Operation
- The FSM has four states: IDLE, XFER, RELEASE and SETTLE. `grant_release` is 1 exactly in the RELEASE state.
- **IDLE:** when `grant_valid` is 1, latch `grant` into `sel` and `grant_oh` into `sel_oh`, clear `beat_cnt`, and go to XFER. Otherwise remain in IDLE.
- **XFER:**
  - `req_ready = sel_oh & {N{out_free}}`, where `out_free = ~out_valid | out_ready`.
  - An input beat is accepted when `req_valid[sel] & out_free`. On acceptance, the output register loads `req_data[sel]`, `req_last[sel] | force` and `sel`, and `beat_cnt` increments.
  - `force = (beat_cnt == C_MAX_BEATS-1)`. When an accepted beat has `force=1` and `req_last[sel]=0`, set `err_overflow`.
  - An accepted beat with the loaded last flag set moves the FSM to RELEASE.
- **RELEASE:** `grant_release=1` and all `req_ready` bits are 0. Go to SETTLE unconditionally.
- **SETTLE:** the arbiter has dropped `grant_valid` this cycle. Go to IDLE unconditionally. This prevents latching the stale grant.
- **Output register:** if `out_valid & ~out_ready`, hold all output fields. Otherwise `out_valid` follows acceptance.
- `grant_valid` deasserting during XFER is ignored; `sel` is held until the packet ends.
- A source that drops `req_valid` mid-packet stalls the transfer; there is no timeout on gaps.

## Timing
- Reset values: `req_ready=0`, `grant_release=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `out_src=0`, `err_overflow=0`, FSM in IDLE, `beat_cnt=0`.
- Assertion of `rst` mid-packet abandons the packet immediately. No release pulse is issued, because the arbiter is reset on the same `rst`.
- Latency: 1 cycle from input acceptance to `out_valid`. Full throughput of 1 beat/cycle is sustained while `out_ready=1`.
- Grant edge at cycle t → IDLE sees it → XFER at t+1 with first accept possible at t+1.
- Last beat accepted at cycle t → RELEASE at t+1 → SETTLE at t+2 → IDLE at t+3. The next grant can be latched at t+3, so the inter-packet gap is ≥ 3 cycles.
- The output register may still be holding the last beat during RELEASE and SETTLE. This is legal; a new XFER accepts only when `out_free`.
- `beat_cnt` never exceeds `C_MAX_BEATS`; it clears on every IDLE→XFER transition.

## Structure
- Shared package: FSM state encoding (2 bits: IDLE=0, XFER=1, RELEASE=2, SETTLE=3), the `clog2` function (existing `math.svh`), and the parameter-legality checks.
- One sub-module is natural: `stream_out_reg`, a single-entry valid/ready output register carrying data, last and src. The mux, FSM and counter remain in the top module.

## Test plan
- N=4, only source 2 sends a 3-beat packet with `out_ready=1` → 3 beats with `out_src=2`, `out_last` on beat 3, one `grant_release` pulse 1 cycle after the last accept, `err_overflow=0`.
- Sources 0 and 1 are both valid with 2-beat packets → the packets are never interleaved, each packet is followed by exactly one `grant_release`, and both packets are delivered.
- `out_ready` is held 0 for 5 cycles mid-packet → `out_data` is stable, `req_ready[sel]=0` while `out_valid=1`, and no beat is lost or duplicated.
- `C_MAX_BEATS=4`, source sends 6 beats without last → beat 4 carries forced `out_last=1`, `err_overflow=1` (sticky), then release. The remaining 2 beats form a new packet after re-grant.
- `rst` is asserted at beat 2 of 5 → the next cycle shows every output at its reset value and the FSM in IDLE. After reset, a fresh packet transfers correctly.
- The arbiter drops `grant_valid` during XFER (forced) → `sel` is unchanged and the packet completes from the original source.
